// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-outstanding memory with timeout
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_valid_i,
    input  logic        m0_wen_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [3:0]  m0_strb_i,
    output logic [31:0] m0_rdata_o,
    output logic        m0_done_o,
    output logic        m0_err_o,
    input  logic        m1_valid_i,
    input  logic        m1_wen_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic [3:0]  m1_strb_i,
    output logic [31:0] m1_rdata_o,
    output logic        m1_done_o,
    output logic        m1_err_o,
    output logic        mem_valid_o,
    output logic        mem_wen_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_strb_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_done_i
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
    state_e      state_q;
    logic [7:0]  cnt_q;
    logic        last_q, gnt_q, gnt_d;
    logic        mv_q, wen_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  strb_q;
    logic [1:0]  done_q, err_q;
    logic [31:0] rdata_q [2];
    logic        fin_d;
    assign gnt_d = (m0_valid_i && m1_valid_i) ? ~last_q : m1_valid_i;
    assign fin_d = mem_done_i || (cnt_q == 8'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            mv_q    <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            done_q  <= '0;
            err_q   <= '0;
            rdata_q <= '{default: '0};
        end else begin
            mv_q   <= 1'b0;
            done_q <= '0;
            case (state_q)
                IDLE: if (m0_valid_i || m1_valid_i) begin
                    gnt_q   <= gnt_d;
                    wen_q   <= gnt_d ? m1_wen_i   : m0_wen_i;
                    addr_q  <= gnt_d ? m1_addr_i  : m0_addr_i;
                    wdata_q <= gnt_d ? m1_wdata_i : m0_wdata_i;
                    strb_q  <= gnt_d ? m1_strb_i  : m0_strb_i;
                    mv_q    <= 1'b1;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: if (fin_d) begin
                    // a real completion wins over a timeout landing in the same cycle
                    rdata_q[gnt_q] <= mem_done_i ? mem_rdata_i : '0;
                    err_q[gnt_q]   <= ~mem_done_i;
                    done_q[gnt_q]  <= 1'b1;
                    state_q        <= RESP;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
                RESP: begin
                    last_q  <= gnt_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign mem_valid_o = mv_q;
    assign mem_wen_o   = wen_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_strb_o  = strb_q;
    assign m0_done_o   = done_q[0];
    assign m1_done_o   = done_q[1];
    assign m0_err_o    = err_q[0];
    assign m1_err_o    = err_q[1];
    assign m0_rdata_o  = rdata_q[0];
    assign m1_rdata_o  = rdata_q[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: transaction-scheduling reference model checked against mem_arbiter every cycle
module tb_mem_arbiter;
    localparam int T = 16;
    logic        clk = 1'b0, rst = 1'b1;
    logic        v [2], wen [2], done_o [2], err_o [2];
    logic [31:0] addr [2], wdata [2], rdata_o [2];
    logic [3:0]  strb [2];
    logic        mv, mwen, mdone;
    logic [31:0] maddr, mwdata, mrdata;
    logic [3:0]  mstrb;

    mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_valid_i(v[0]), .m0_wen_i(wen[0]), .m0_addr_i(addr[0]), .m0_wdata_i(wdata[0]),
        .m0_strb_i(strb[0]), .m0_rdata_o(rdata_o[0]), .m0_done_o(done_o[0]), .m0_err_o(err_o[0]),
        .m1_valid_i(v[1]), .m1_wen_i(wen[1]), .m1_addr_i(addr[1]), .m1_wdata_i(wdata[1]),
        .m1_strb_i(strb[1]), .m1_rdata_o(rdata_o[1]), .m1_done_o(done_o[1]), .m1_err_o(err_o[1]),
        .mem_valid_o(mv), .mem_wen_o(mwen), .mem_addr_o(maddr), .mem_wdata_o(mwdata),
        .mem_strb_o(mstrb), .mem_rdata_i(mrdata), .mem_done_i(mdone)
    );

    always #5 clk = ~clk;

    int cyc = 0, total = 0, bad = 0;
    int mode = 0;
    int free_at = 0, iss_cyc = -1, resp_cyc = -1, rst_cyc = 1, g = 0, gcyc = -1;
    int rel_at [2] = '{-1, -1};
    bit pend [2] = '{0, 0};
    bit last = 1'b1;
    int plan_d = 0;
    bit plan_early = 1'b0;
    logic [31:0] plan_rd = '0, pulse_rd = '0, exp_rd = '0;
    bit exp_err = 1'b0;
    int pulse_a = -1, pulse_b = -1;
    logic        e_wen = 1'b0, n_wen = 1'b0;
    logic [31:0] e_addr = '0, e_wdata = '0, n_addr = '0, n_wdata = '0;
    logic [3:0]  e_strb = '0, n_strb = '0;
    int gq [$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic req(int i, logic w, logic [31:0] a, logic [31:0] d, logic [3:0] s);
        pend[i] = 1'b1;
        wen[i] = w; addr[i] = a; wdata[i] = d; strb[i] = s;
    endtask

    task automatic newreq(int i);
        req(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
    endtask

    task automatic tick(bit r = 1'b0);
        int gg;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc == iss_cyc) begin
            e_wen = n_wen; e_addr = n_addr; e_wdata = n_wdata; e_strb = n_strb;
        end
        chk("mem_valid", mv, 32'(cyc == iss_cyc));
        chk("mem_wen", mwen, e_wen);
        chk("mem_addr", maddr, e_addr);
        chk("mem_wdata", mwdata, e_wdata);
        chk("mem_strb", mstrb, e_strb);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("done%0d", i), done_o[i], 32'(cyc == resp_cyc && g == i));
            if (cyc == resp_cyc && g == i) begin
                chk($sformatf("rdata%0d", i), rdata_o[i], exp_rd);
                chk($sformatf("err%0d", i), err_o[i], exp_err);
            end
            if (cyc == rst_cyc) begin
                chk($sformatf("rst_rdata%0d", i), rdata_o[i], 0);
                chk($sformatf("rst_err%0d", i), err_o[i], 0);
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (pend[i] && cyc == rel_at[i]) pend[i] = 1'b0;
            if (!pend[i] && (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0))) newreq(i);
        end
        mdone  = (cyc == pulse_a) || (cyc == pulse_b);
        mrdata = (cyc == pulse_a) ? pulse_rd : $urandom;
        rst    = r;
        if (r) begin
            free_at = cyc + 1; iss_cyc = -1; resp_cyc = -1; rst_cyc = cyc + 1; last = 1'b1;
            pend = '{0, 0}; rel_at = '{-1, -1};
            e_wen = 1'b0; e_addr = '0; e_wdata = '0; e_strb = '0;
        end else if (cyc >= free_at && (pend[0] || pend[1])) begin
            gg = (pend[0] && pend[1]) ? int'(!last) : int'(pend[1]);
            if (mode == 2) begin
                case ($urandom_range(0, 9))
                    7: plan_d = T - 1;
                    8: plan_d = T;
                    9: plan_d = -1;
                    default: plan_d = $urandom_range(0, 3);
                endcase
                plan_early = ($urandom_range(0, 7) == 0);
                plan_rd = $urandom;
            end
            g = gg; last = gg[0]; gcyc = cyc; gq.push_back(gg);
            iss_cyc = cyc + 1;
            n_wen = wen[gg]; n_addr = addr[gg]; n_wdata = wdata[gg]; n_strb = strb[gg];
            pulse_rd = plan_rd;
            if (plan_d >= 0 && plan_d < T) begin
                pulse_a = cyc + 2 + plan_d; resp_cyc = cyc + 3 + plan_d; exp_rd = plan_rd; exp_err = 1'b0;
            end else begin
                pulse_a = (plan_d == T) ? cyc + 2 + T : -1;
                resp_cyc = cyc + 2 + T; exp_rd = '0; exp_err = 1'b1;
            end
            pulse_b = plan_early ? cyc + 1 : -1;
            free_at = resp_cyc + 1;
            rel_at[gg] = resp_cyc + 1;
        end
        for (int i = 0; i < 2; i++) v[i] = pend[i];
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((cyc < free_at || pend[0] || pend[1]) && guard < 2000) begin
            tick();
            guard++;
        end
        chk("idle_bound", 32'(guard >= 2000), 0);
    endtask

    initial begin
        int n, guard;
        mdone = 1'b0; mrdata = '0;
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0; wen[i] = 1'b0; addr[i] = '0; wdata[i] = '0; strb[i] = '0;
        end
        tick(1); tick(1);
        // both requesters held valid from reset, zero-wait memory
        gq.delete();
        plan_d = 0; plan_early = 1'b0; plan_rd = 32'h0BAD_F00D;
        mode = 1; newreq(0); newreq(1);
        guard = 0;
        while (gq.size() < 4 && guard < 200) begin tick(); guard++; end
        mode = 0;
        wait_idle();
        chk("rr_count", 32'(gq.size() >= 4), 1);
        if (gq.size() >= 4) begin
            chk("rr_g0", gq[0], 0); chk("rr_g1", gq[1], 1);
            chk("rr_g2", gq[2], 0); chk("rr_g3", gq[3], 1);
        end
        // m0 read of 0x100, one-cycle memory
        plan_d = 0; plan_rd = 32'hDEADBEEF;
        req(0, 1'b0, 32'h100, 32'h0, 4'hF);
        tick(); n = cyc;
        chk("r32_grant", gcyc, n);
        tick(); chk("r32_mv", mv, 1); chk("r32_addr", maddr, 32'h100);
        tick(); tick();
        chk("r32_done", done_o[0], 1); chk("r32_rdata", rdata_o[0], 32'hDEADBEEF); chk("r32_err", err_o[0], 0);
        wait_idle();
        // m1 write while m0 idle
        plan_d = 1; plan_rd = 32'h5555_AAAA;
        req(1, 1'b1, 32'h40, 32'h12345678, 4'h3);
        tick(); n = cyc;
        tick();
        chk("r34_mv", mv, 1); chk("r34_wen", mwen, 1); chk("r34_addr", maddr, 32'h40);
        chk("r34_wdata", mwdata, 32'h12345678); chk("r34_strb", mstrb, 4'h3);
        repeat (3) tick();
        chk("r34_done1", done_o[1], 1); chk("r34_done0", done_o[0], 0);
        wait_idle();
        // memory never answers: timeout
        plan_d = -1;
        req(0, 1'b0, 32'h200, 32'h0, 4'hF);
        tick(); n = cyc;
        while (cyc < n + 17) tick();
        chk("r35_early", done_o[0], 0);
        tick();
        chk("r35_done", done_o[0], 1); chk("r35_err", err_o[0], 1); chk("r35_rdata", rdata_o[0], 0);
        wait_idle();
        plan_d = 0; plan_rd = 32'hCAFE_0001;
        req(0, 1'b0, 32'h204, 32'h0, 4'hF);
        tick(); n = cyc;
        repeat (3) tick();
        chk("r35_next", done_o[0], 1); chk("r35_next_err", err_o[0], 0); chk("r35_next_rd", rdata_o[0], 32'hCAFE_0001);
        wait_idle();
        // done pulse in the issue cycle is ignored
        plan_d = -1; plan_early = 1'b1;
        req(0, 1'b0, 32'h300, 32'h0, 4'hF);
        tick(); n = cyc;
        while (cyc < n + 18) tick();
        chk("r36_done", done_o[0], 1); chk("r36_err", err_o[0], 1);
        plan_early = 1'b0;
        wait_idle();
        // reset in WAIT, late done afterwards
        plan_d = 2; plan_rd = 32'h7777_7777;
        req(0, 1'b0, 32'h400, 32'h0, 4'hF);
        tick(); n = cyc;
        tick(); tick();
        tick(1);
        plan_d = 0; plan_rd = 32'h1357_9BDF;
        req(1, 1'b0, 32'h500, 32'h0, 4'hF);
        tick();
        chk("r37_mv", mv, 0); chk("r37_done0", done_o[0], 0); chk("r37_addr", maddr, 0);
        n = cyc;
        tick(); tick();
        chk("r37_nodone", done_o[0], 0);
        tick();
        chk("r37_done1", done_o[1], 1); chk("r37_rdata", rdata_o[1], 32'h1357_9BDF);
        wait_idle();
        // random traffic
        mode = 2;
        repeat (4000) tick();
        mode = 0;
        wait_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
